// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and fill-state encoding for the pattern detector
package seq_det_pkg;

  localparam int SEQ_PAT_LEN = 4;
  localparam int SEQ_CNT_W = 8;
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_DEFAULT_PAT = 4'b1001;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter; clear is applied before the increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (base != {W{1'b1}})) begin
      count <= base + W'(1);
    end else begin
      count <= base;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-programmable serial pattern detector with match counter
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = SEQ_PAT_LEN,
  parameter int CNT_W = SEQ_CNT_W,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(SEQ_DEFAULT_PAT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               w,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FIL_W = $clog2(PAT_LEN + 1);
  localparam logic [FIL_W-1:0] FULL = FIL_W'(PAT_LEN);
  localparam logic [FIL_W-1:0] FULL_M1 = FIL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-1:0] hist;
  logic [FIL_W-1:0]   fill;
  fill_state_e        state;

  logic               accept;
  logic               full_n;
  logic [PAT_LEN-1:0] hist_n;
  logic [FIL_W-1:0]   fill_n;
  logic               match;

  // Once armed the history window stays full, so fill only matters while filling.
  always_comb begin
    accept = in_valid & ~pat_load;
    hist_n = {hist[PAT_LEN-2:0], w};
    full_n = (state == ARMED) || (fill == FULL_M1);
    fill_n = full_n ? FULL : fill + FIL_W'(1);
    match  = accept && full_n && (hist_n == pat_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_reg <= DEFAULT_PAT;
      hist    <= '0;
      fill    <= '0;
      state   <= FILLING;
      z       <= 1'b0;
    end else begin
      z <= match;
      if (pat_load) begin
        pat_reg <= pat_in;
        hist    <= '0;
        fill    <= '0;
        state   <= FILLING;
      end else if (accept) begin
        if (match && !overlap_en) begin
          hist  <= '0;
          fill  <= '0;
          state <= FILLING;
        end else begin
          hist  <= hist_n;
          fill  <= fill_n;
          state <= full_n ? ARMED : FILLING;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (count_clr),
    .inc  (match),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - scoreboard bench for seq_pattern_detector
module tb_seq_pattern_detector;

  localparam int PAT_LEN = 4;
  localparam int CNT_W = 2;
  localparam logic [PAT_LEN-1:0] DEF_PAT = 4'b1001;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               w;
  logic               overlap_en;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               count_clr;
  logic               z;
  logic [CNT_W-1:0]   match_count;

  int n_vec;
  int n_err;

  bit               m_bits[$];
  logic [PAT_LEN-1:0] m_pat;
  int               m_cnt;
  int               exp_z_q[$];
  int               exp_c_q[$];

  seq_pattern_detector #(
    .PAT_LEN(PAT_LEN),
    .CNT_W(CNT_W),
    .DEFAULT_PAT(DEF_PAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .w          (w),
    .overlap_en (overlap_en),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .count_clr  (count_clr),
    .z          (z),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: last PAT_LEN accepted bits kept as a list and compared bit-for-bit.
  task automatic step(input logic v, input logic b, input logic ov,
                      input logic pl, input logic [PAT_LEN-1:0] pi, input logic cc,
                      input string tag);
    int ez;
    int p;
    in_valid = v; w = b; overlap_en = ov; pat_load = pl; pat_in = pi; count_clr = cc;
    ez = 0;
    if (pl) begin
      m_pat = pi;
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_LEN) begin
        p = 0;
        foreach (m_bits[i]) p = (p << 1) | int'(m_bits[i]);
        ez = (p == int'(m_pat)) ? 1 : 0;
      end
      if (ez == 1 && !ov) m_bits.delete();
    end
    if (cc) m_cnt = 0;
    if (ez == 1 && m_cnt < CNT_MAX) m_cnt++;
    exp_z_q.push_back(ez);
    exp_c_q.push_back(m_cnt);
    @(posedge clk);
    #1;
    check({tag, ".z"}, 32'(z), 32'(exp_z_q.pop_front()));
    check({tag, ".cnt"}, 32'(match_count), 32'(exp_c_q.pop_front()));
    @(negedge clk);
  endtask

  task automatic bits_in(input logic [15:0] seq, input int n, input logic ov, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, seq[i], ov, 1'b0, '0, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, tag);
  endtask

  // Reset is raised between edges so the async clear is visible before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check({tag, ".rst_z"}, 32'(z), 32'd0);
    check({tag, ".rst_cnt"}, 32'(match_count), 32'd0);
    m_bits.delete();
    m_pat = DEF_PAT;
    m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; in_valid = 0; w = 0; overlap_en = 1; pat_load = 0; pat_in = '0; count_clr = 0;
    m_pat = DEF_PAT; m_cnt = 0;
    @(negedge clk);
    do_reset("init");

    bits_in(16'b1001001, 7, 1'b1, "ovl");
    check("ovl.final", 32'(match_count), 32'd2);

    do_reset("r2");
    bits_in(16'b1001001, 7, 1'b0, "novl");
    check("novl.final", 32'(match_count), 32'd1);

    do_reset("r3");
    bits_in(16'b1, 1, 1'b1, "gap");
    idle(3, "gap.idle");
    bits_in(16'b001, 3, 1'b1, "gap");
    check("gap.final", 32'(match_count), 32'd1);

    do_reset("r4");
    bits_in(16'b10, 2, 1'b1, "reload.pre");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0, "reload.load");
    bits_in(16'b1101101, 7, 1'b1, "reload");
    check("reload.final", 32'(match_count), 32'd2);

    do_reset("r5");
    bits_in(16'b1001, 4, 1'b1, "sat");
    for (int k = 0; k < 4; k++) bits_in(16'b001, 3, 1'b1, "sat");
    check("sat.held", 32'(match_count), 32'(CNT_MAX));
    bits_in(16'b00, 2, 1'b1, "sat.pre");
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, "sat.clr");
    check("sat.clr_final", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "clr.only");

    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, "mid.load");
    bits_in(16'b100, 3, 1'b1, "mid");
    do_reset("r6");
    bits_in(16'b1, 1, 1'b1, "mid.after");
    check("mid.cnt", 32'(match_count), 32'd0);
    bits_in(16'b001, 3, 1'b1, "mid.defpat");
    check("mid.defpat_cnt", 32'(match_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Runtime-programmable serial bit-pattern detector. It is a parametrised generalisation of the team's fixed 4-bit sequence detector FSMs.
- Supports configurable pattern length, runtime pattern load, and an input-valid qualifier.
- Selects overlapping or non-overlapping detection.
- Keeps a saturating match counter.
- Sits between a serial bit source and control/status logic. z is a Moore-style registered match pulse.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, match counter width; legal range 1..32.
DEFAULT_PAT, 4'b1001 (PAT_LEN bits), pattern loaded on reset.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  w is sampled only when in_valid=1.
w  input  1  serial data bit.
overlap_en  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
pat_load  input  1  load pat_in as the new pattern.
pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received.
count_clr  input  1  synchronous clear of match_count.
z  output  1  match pulse, registered.
match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (async, active-high):
  - pat_reg = DEFAULT_PAT, hist = 0, fill = 0, z = 0, match_count = 0.
  - Reset asserted mid-pattern discards all partial history.
- State held in registers:
  - pat_reg[PAT_LEN-1:0].
  - hist[PAT_LEN-1:0], a shift register: new bit enters the LSB and hist shifts left.
  - fill, range 0..PAT_LEN, saturating at PAT_LEN.
- Fill FSM:
  - FILLING: fill < PAT_LEN.
  - ARMED: fill == PAT_LEN.
  - FILLING -> ARMED after PAT_LEN accepted bits since the last clear.
  - ARMED -> FILLING on pat_load, or on a match when overlap_en=0.
- Accept: a bit is accepted on a rising clk edge when in_valid=1 and pat_load=0.
  - hist_n = {hist[PAT_LEN-2:0], w}.
  - fill_n = min(fill+1, PAT_LEN).
- Match condition: bit accepted AND fill_n == PAT_LEN AND hist_n == pat_reg.
- z timing:
  - z is registered to the match condition, so it goes high on the edge that accepts the completing bit.
  - z stays high for exactly one clk cycle.
  - z is low in every other cycle, including cycles with in_valid=0.
- On a match:
  - overlap_en=1: hist and fill keep their _n values, so the next match may share bits.
  - overlap_en=0: hist = 0 and fill = 0 on that edge, so the next match needs PAT_LEN fresh bits.
  - overlap_en is sampled on the accepting edge only.
- in_valid=0: hist, fill and pat_reg hold; gaps of any length between bits are transparent.
- pat_load=1 (priority over accept):
  - pat_reg = pat_in, hist = 0, fill = 0, z = 0 next cycle.
  - w is ignored that cycle.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1 with no wrap.
  - count_clr=1 sets it to 0; if a match occurs in the same cycle, the result is 1 (clear first, then count).
- No combinational path from inputs to outputs.

Decomposition:
- Package seq_det_pkg holds:
  - default constants: PAT_LEN, CNT_W, DEFAULT_PAT;
  - the fill-state encoding: FILLING, ARMED.
- One natural sub-module: sat_counter (parametrised width, inc, clr, saturating). It is instantiated for match_count and reusable elsewhere.

Test Plan:
- Overlap, default pattern 1001: reset, overlap_en=1, in_valid=1, stream 1,0,0,1,0,0,1 -> z high one cycle after bit 4 and after bit 7; match_count=2.
- Non-overlap, same stream with overlap_en=0 -> z pulses only after bit 4; match_count=1.
- Valid gaps: 1, [in_valid=0 for 3 cycles], 0, 0, 1 -> one z pulse after the final 1; z stays 0 during the gap cycles.
- Pattern reload mid-stream: after bits 1,0, pulse pat_load with pat_in=1101, then stream 1,1,0,1,1,0,1 with overlap_en=1 -> pulses after bits 4 and 7; the earlier 1,0 does not contribute; match_count increases by 2.
- Saturation and clear, CNT_W=2: 5 matches -> match_count=3 (held). count_clr asserted together with the 6th match -> match_count=1.
- Reset mid-pattern: stream 1,0,0, assert reset, then stream 1 -> no z pulse; match_count=0; pattern back to DEFAULT_PAT.
